// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage operand resolution for the OpenMIPS pipeline.
// Operands come from a fixed-priority chain of forwarding sources, the register
// file or the immediate. A per-register countdown scoreboard tracks writers
// whose results are not yet forwardable and raises a load-use stall. The
// resolved operands are registered into an ID/EX slot with stall, bubble and
// flush handling.
module id_operand_stage #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    parameter  int NFWD   = 2,
    parameter  int LAT_W  = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic                   rd1_en_i,
    input  logic                   rd2_en_i,
    input  logic [AW-1:0]          rd1_addr_i,
    input  logic [AW-1:0]          rd2_addr_i,
    input  logic [DATA_W-1:0]      rf1_data_i,
    input  logic [DATA_W-1:0]      rf2_data_i,
    input  logic [DATA_W-1:0]      imm_i,
    input  logic                   issue_wen_i,
    input  logic [AW-1:0]          issue_waddr_i,
    input  logic [LAT_W-1:0]       issue_lat_i,
    input  logic [NFWD-1:0]        fwd_wen_i,
    input  logic [NFWD*AW-1:0]     fwd_addr_i,
    input  logic [NFWD*DATA_W-1:0] fwd_data_i,
    input  logic [NFWD-1:0]        fwd_valid_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      opnd1_o,
    output logic [DATA_W-1:0]      opnd2_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hazard;
    } resolve_t;

    // Cycles remaining until each register's pending result becomes forwardable.
    logic [LAT_W-1:0] pend [NREG];

    resolve_t res1;
    resolve_t res2;
    logic     accept;

    // Walk the forwarding chain youngest-first; the first address match decides
    // the operand even if its data is not final yet, since any older match
    // would be stale. Only with no match does the scoreboard get a say.
    function automatic resolve_t resolve(
        input logic                   en,
        input logic [AW-1:0]          addr,
        input logic [DATA_W-1:0]      rf_data,
        input logic                   busy,
        input logic [DATA_W-1:0]      imm,
        input logic [NFWD-1:0]        fwen,
        input logic [NFWD*AW-1:0]     faddr,
        input logic [NFWD*DATA_W-1:0] fdata,
        input logic [NFWD-1:0]        fvalid
    );
        resolve_t r;
        logic     hit;
        // NOTE: function locals are plain temporaries, so blocking assignments
        // are correct here; the ordering of the loop depends on it.
        r.data   = rf_data;
        r.hazard = 1'b0;
        hit      = 1'b0;
        if (!en) begin
            r.data = imm;
        end else if (addr == '0) begin
            r.data = '0;
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && fwen[k] && faddr[k*AW +: AW] == addr) begin
                    hit = 1'b1;
                    if (fvalid[k]) r.data   = fdata[k*DATA_W +: DATA_W];
                    else           r.hazard = 1'b1;
                end
            end
            if (!hit && busy) r.hazard = 1'b1;
        end
        return r;
    endfunction

    // Resolve both operands and derive the hazard stall and the accept strobe.
    always_comb begin
        res1 = resolve(rd1_en_i, rd1_addr_i, rf1_data_i, pend[rd1_addr_i] != '0,
                       imm_i, fwd_wen_i, fwd_addr_i, fwd_data_i, fwd_valid_i);
        res2 = resolve(rd2_en_i, rd2_addr_i, rf2_data_i, pend[rd2_addr_i] != '0,
                       imm_i, fwd_wen_i, fwd_addr_i, fwd_data_i, fwd_valid_i);
        stall_o = issue_i & ~rst & (res1.hazard | res2.hazard);
        accept  = issue_i & ~stall_o & ~stall_i & ~flush_i;
    end

    // Scoreboard: count down live entries on every un-frozen cycle and arm the
    // destination of a newly accepted long-latency writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the scoreboard is a small flop array, not a RAM, so it can
            // and must be cleared on reset; stale entries would cause phantom
            // stalls after reset.
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else if (!stall_i) begin
            for (int i = 0; i < NREG; i++) begin
                if (pend[i] != '0) pend[i] <= pend[i] - LAT_W'(1);
            end
            // Last assignment wins, so a new writer overrides the decrement.
            if (accept && issue_wen_i && issue_waddr_i != '0 && issue_lat_i != '0)
                pend[issue_waddr_i] <= issue_lat_i;
        end
    end

    // ID/EX slot: reset/flush clears, downstream freeze holds, hazard bubbles.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_o <= 1'b0;
            opnd1_o <= '0;
            opnd2_o <= '0;
        end else if (stall_i) begin
            valid_o <= valid_o;
            opnd1_o <= opnd1_o;
            opnd2_o <= opnd2_o;
        end else if (stall_o) begin
            valid_o <= 1'b0;
            opnd1_o <= '0;
            opnd2_o <= '0;
        end else begin
            valid_o <= issue_i;
            opnd1_o <= res1.data;
            opnd2_o <= res2.data;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: a table of single-cycle resolution
// vectors followed by hand-written multi-cycle scoreboard sequences.
module tb_id_operand_stage;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int NFWD   = 2;
    localparam int LAT_W  = 2;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_i;
    logic              rd1_en_i, rd2_en_i;
    logic [AW-1:0]     rd1_addr_i, rd2_addr_i;
    logic [DATA_W-1:0] rf1_data_i, rf2_data_i, imm_i;
    logic              issue_wen_i;
    logic [AW-1:0]     issue_waddr_i;
    logic [LAT_W-1:0]  issue_lat_i;
    logic [NFWD-1:0]   fwd_wen_i;
    logic [AW-1:0]     fa0, fa1;
    logic [DATA_W-1:0] fd0, fd1;
    logic [NFWD-1:0]   fwd_valid_i;
    logic              stall_i, flush_i;
    logic              stall_o, valid_o;
    logic [DATA_W-1:0] opnd1_o, opnd2_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_operand_stage #(
        .DATA_W(DATA_W), .NREG(NREG), .NFWD(NFWD), .LAT_W(LAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (issue_i),
        .rd1_en_i     (rd1_en_i),
        .rd2_en_i     (rd2_en_i),
        .rd1_addr_i   (rd1_addr_i),
        .rd2_addr_i   (rd2_addr_i),
        .rf1_data_i   (rf1_data_i),
        .rf2_data_i   (rf2_data_i),
        .imm_i        (imm_i),
        .issue_wen_i  (issue_wen_i),
        .issue_waddr_i(issue_waddr_i),
        .issue_lat_i  (issue_lat_i),
        .fwd_wen_i    (fwd_wen_i),
        .fwd_addr_i   ({fa1, fa0}),
        .fwd_data_i   ({fd1, fd0}),
        .fwd_valid_i  (fwd_valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .opnd1_o      (opnd1_o),
        .opnd2_o      (opnd2_o)
    );

    typedef struct {
        logic              issue;
        logic              rd1_en;
        logic [AW-1:0]     rd1_addr;
        logic              rd2_en;
        logic [AW-1:0]     rd2_addr;
        logic [DATA_W-1:0] rf1, rf2, imm;
        logic [NFWD-1:0]   fwen;
        logic [AW-1:0]     a0, a1;
        logic [DATA_W-1:0] d0, d1;
        logic [NFWD-1:0]   fvalid;
        logic              exp_stall;
        logic              exp_valid;
        logic [DATA_W-1:0] exp1, exp2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_i = 0; rd1_en_i = 0; rd2_en_i = 0; rd1_addr_i = '0; rd2_addr_i = '0;
        rf1_data_i = '0; rf2_data_i = '0; imm_i = '0;
        issue_wen_i = 0; issue_waddr_i = '0; issue_lat_i = '0;
        fwd_wen_i = '0; fa0 = '0; fa1 = '0; fd0 = '0; fd1 = '0; fwd_valid_i = '0;
        stall_i = 0; flush_i = 0;
    endtask

    // Present a writer that reads nothing, so it is always accepted.
    task automatic issue_writer(input logic [AW-1:0] waddr, input logic [LAT_W-1:0] lat);
        clear_inputs();
        issue_i = 1; issue_wen_i = 1; issue_waddr_i = waddr; issue_lat_i = lat;
    endtask

    initial begin
        //           iss r1e r1a r2e r2a rf1       rf2       imm    fwen   a0 a1 d0        d1        fval   stl val exp1      exp2
        vecs[0] = '{1, 1, 5,  0, 0,  32'hAAAA, 32'hBBBB, 32'h77, 2'b11, 5, 5, 32'h11,   32'h22,   2'b11, 0, 1, 32'h11,   32'h77};
        vecs[1] = '{1, 1, 5,  1, 6,  32'hAAAA, 32'hBBBB, 32'h0,  2'b11, 6, 5, 32'h11,   32'h22,   2'b11, 0, 1, 32'h22,   32'h11};
        vecs[2] = '{1, 1, 9,  1, 10, 32'h1234, 32'h5678, 32'h0,  2'b00, 9, 10,32'hDEAD, 32'hBEEF, 2'b11, 0, 1, 32'h1234, 32'h5678};
        vecs[3] = '{1, 1, 0,  1, 0,  32'hAAAA, 32'hBBBB, 32'h1,  2'b11, 0, 0, 32'hFFFF, 32'hEEEE, 2'b11, 0, 1, 32'h0,    32'h0};
        vecs[4] = '{1, 0, 0,  1, 3,  32'h0,    32'h9999, 32'h5,  2'b11, 3, 3, 32'h0,    32'hABCD, 2'b10, 1, 0, 32'h0,    32'h0};
        vecs[5] = '{1, 0, 3,  1, 4,  32'h33,   32'h44,   32'h55, 2'b01, 3, 0, 32'h1,    32'h0,    2'b00, 0, 1, 32'h55,   32'h44};
        vecs[6] = '{0, 1, 8,  0, 0,  32'h88,   32'h0,    32'h99, 2'b00, 0, 0, 32'h0,    32'h0,    2'b00, 0, 0, 32'h88,   32'h99};
        vecs[7] = '{1, 1, 12, 1, 12, 32'hC,    32'hD,    32'h0,  2'b11, 12,12,32'h1212, 32'h2121, 2'b01, 0, 1, 32'h1212, 32'h1212};

        // Reset state, with a would-be hazard on the inputs.
        clear_inputs();
        rst = 1;
        issue_i = 1; rd1_en_i = 1; rd1_addr_i = 3; fwd_wen_i = 2'b01; fa0 = 3;
        cyc(); cyc();
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_opnd1", opnd1_o, 32'd0);
        check("reset_opnd2", opnd2_o, 32'd0);
        rst = 0;
        clear_inputs();
        cyc();

        // Single-cycle resolution vectors on an empty scoreboard.
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            issue_i = vecs[i].issue;
            rd1_en_i = vecs[i].rd1_en; rd1_addr_i = vecs[i].rd1_addr;
            rd2_en_i = vecs[i].rd2_en; rd2_addr_i = vecs[i].rd2_addr;
            rf1_data_i = vecs[i].rf1; rf2_data_i = vecs[i].rf2; imm_i = vecs[i].imm;
            fwd_wen_i = vecs[i].fwen; fa0 = vecs[i].a0; fa1 = vecs[i].a1;
            fd0 = vecs[i].d0; fd1 = vecs[i].d1; fwd_valid_i = vecs[i].fvalid;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
            cyc();
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_opnd1", i), opnd1_o, vecs[i].exp1);
            check($sformatf("vec%0d_opnd2", i), opnd2_o, vecs[i].exp2);
        end

        // Load-use: load to r3, lat=1, then a reader of r3.
        issue_writer(3, 1);
        #1 check("lu_writer_stall", 32'(stall_o), 32'd0);
        cyc();
        check("lu_writer_valid", 32'(valid_o), 32'd1);
        clear_inputs();
        rd2_en_i = 1; rd2_addr_i = 3; rf2_data_i = 32'h9999;
        fwd_wen_i = 2'b01; fa0 = 3; fwd_valid_i = 2'b00;
        #1 check("lu_no_issue_stall", 32'(stall_o), 32'd0);
        issue_i = 1;
        #1 check("lu_stall", 32'(stall_o), 32'd1);
        cyc();
        check("lu_bubble_valid", 32'(valid_o), 32'd0);
        check("lu_bubble_opnd2", opnd2_o, 32'd0);
        fwd_wen_i = 2'b10; fa1 = 3; fd1 = 32'hABCD; fwd_valid_i = 2'b10;
        #1 check("lu_release_stall", 32'(stall_o), 32'd0);
        cyc();
        check("lu_fwd_valid", 32'(valid_o), 32'd1);
        check("lu_fwd_opnd2", opnd2_o, 32'hABCD);

        // Scoreboard-only hazard on r4 with lat=2 counts down over two cycles.
        issue_writer(4, 2);
        cyc();
        clear_inputs();
        issue_i = 1; rd1_en_i = 1; rd1_addr_i = 4; rf1_data_i = 32'h4;
        #1 check("sb_stall_2", 32'(stall_o), 32'd1);
        cyc();
        check("sb_stall_1", 32'(stall_o), 32'd1);
        cyc();
        check("sb_stall_0", 32'(stall_o), 32'd0);
        cyc();
        check("sb_rf_opnd1", opnd1_o, 32'h4);
        check("sb_rf_valid", 32'(valid_o), 32'd1);

        // Early release: pending r4 is satisfied by a valid forward.
        issue_writer(4, 2);
        cyc();
        clear_inputs();
        issue_i = 1; rd1_en_i = 1; rd1_addr_i = 4; rf1_data_i = 32'h4;
        fwd_wen_i = 2'b01; fa0 = 4; fd0 = 32'h4444; fwd_valid_i = 2'b01;
        #1 check("early_stall", 32'(stall_o), 32'd0);
        cyc();
        check("early_opnd1", opnd1_o, 32'h4444);

        // Freeze: writer to r7 lat=2, then three frozen cycles.
        issue_writer(7, 2);
        rd1_en_i = 1; rd1_addr_i = 8; rf1_data_i = 32'h80;
        cyc();
        check("frz_writer_opnd1", opnd1_o, 32'h80);
        clear_inputs();
        issue_i = 1; rd1_en_i = 1; rd1_addr_i = 7; rf1_data_i = 32'h70;
        stall_i = 1;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("frz%0d_stall", c), 32'(stall_o), 32'd1);
            cyc();
            check($sformatf("frz%0d_valid", c), 32'(valid_o), 32'd1);
            check($sformatf("frz%0d_opnd1", c), opnd1_o, 32'h80);
        end
        stall_i = 0;
        #1 check("frz_rel_stall_2", 32'(stall_o), 32'd1);
        cyc();
        check("frz_rel_bubble", 32'(valid_o), 32'd0);
        check("frz_rel_stall_1", 32'(stall_o), 32'd1);
        cyc();
        check("frz_rel_stall_0", 32'(stall_o), 32'd0);
        cyc();
        check("frz_rel_opnd1", opnd1_o, 32'h70);
        check("frz_rel_valid", 32'(valid_o), 32'd1);

        // Flush and stall together: flush clears the slot, scoreboard holds.
        issue_writer(11, 1);
        cyc();
        check("fs_pre_valid", 32'(valid_o), 32'd1);
        issue_writer(9, 3);
        rd1_en_i = 1; rd1_addr_i = 12; rf1_data_i = 32'h12;
        rd2_en_i = 1; rd2_addr_i = 13; rf2_data_i = 32'h13;
        flush_i = 1; stall_i = 1;
        cyc();
        check("fs_valid", 32'(valid_o), 32'd0);
        check("fs_opnd1", opnd1_o, 32'd0);
        check("fs_opnd2", opnd2_o, 32'd0);
        clear_inputs();
        issue_i = 1; rd2_en_i = 1; rd2_addr_i = 9;
        #1 check("fs_r9_not_set", 32'(stall_o), 32'd0);
        rd1_en_i = 1; rd1_addr_i = 11;
        #1 check("fs_r11_held", 32'(stall_o), 32'd1);
        cyc();
        check("fs_r11_done", 32'(stall_o), 32'd0);

        // Reset during a hazard on r4 (lat=3).
        issue_writer(4, 3);
        cyc();
        clear_inputs();
        issue_i = 1; rd1_en_i = 1; rd1_addr_i = 4;
        #1 check("rst_pre_stall", 32'(stall_o), 32'd1);
        rst = 1;
        #1 check("rst_forced_stall", 32'(stall_o), 32'd0);
        cyc();
        rst = 0;
        #1;
        check("rst_post_stall", 32'(stall_o), 32'd0);
        check("rst_post_valid", 32'(valid_o), 32'd0);
        check("rst_post_opnd1", opnd1_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised operand-resolution and ID/EX staging block for the OpenMIPS pipeline. It generalises decode-stage operand selection to any number of forwarding sources with fixed priority. It adds a per-register scoreboard that tracks long-latency writers such as loads and HI/LO-to-GPR moves, and raises a load-use stall. Resolved operands are registered into an ID/EX pipeline register that supports stall, bubble and flush.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- NREG, 32, architectural registers; AW = clog2(NREG)
- NFWD, 2, forwarding sources; index 0 = youngest stage, highest priority
- LAT_W, 2, width of latency field and scoreboard counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- issue_i  in  1  ID holds a valid instruction
- rd1_en_i / rd2_en_i  in  1  operand 1/2 read from register file (else immediate)
- rd1_addr_i / rd2_addr_i  in  AW  source register addresses
- rf1_data_i / rf2_data_i  in  DATA_W  register-file read data
- imm_i  in  DATA_W  decoded immediate
- issue_wen_i  in  1  instruction writes a GPR
- issue_waddr_i  in  AW  destination register
- issue_lat_i  in  LAT_W  extra cycles before result is forwardable (0 = ALU result)
- fwd_wen_i  in  NFWD  source k writes a GPR
- fwd_addr_i  in  NFWD*AW  source k destination, slice k
- fwd_data_i  in  NFWD*DATA_W  source k data, slice k
- fwd_valid_i  in  NFWD  source k data is final (0 for a load still in EX)
- stall_i  in  1  downstream freeze
- flush_i  in  1  kill the instruction in ID
- stall_o  out  1  hazard stall request to IF/ID (combinational)
- valid_o  out  1  ID/EX slot holds a live instruction
- opnd1_o / opnd2_o  out  DATA_W  registered operands

## Operation
- Register 0 always resolves to 0. It is never forwarded or scoreboarded.
- Resolution per operand when rdN_en_i=1: scan the forwarding sources from k=0 upward. The first k with fwd_wen_i[k] and a matching address is the hit.
  - If the hit has fwd_valid_i=1, use fwd_data_i[k].
  - If the hit has fwd_valid_i=0, raise a hazard.
  - With no hit, use rfN_data_i.
- Unread operand (rdN_en_i=0): use imm_i.
- Scoreboard holds pend[r] of LAT_W bits per register. A register with pend[r]≠0 that is read with no valid forward hit raises a hazard.
- stall_o = issue_i & (hazard on an enabled operand 1 or operand 2). Forced to 0 during rst.
- accept = issue_i & ~stall_o & ~stall_i & ~flush_i.
- Scoreboard update per cycle when ~stall_i:
  - Every nonzero pend decrements by 1.
  - Then, if accept & issue_wen_i & waddr≠0 & issue_lat_i≠0, set pend[waddr] to issue_lat_i. A set overrides the decrement on the same register.
- When stall_i=1, the scoreboard holds.
- flush_i does not clear the scoreboard, because older writers still complete.
- ID/EX register, in priority order:
  1. rst or flush_i: valid_o=0, operands 0.
  2. stall_i: hold all fields.
  3. stall_o: bubble, valid_o=0, operands 0.
  4. Otherwise: valid_o=issue_i, operands take the resolved values.

## Timing
- Reset: valid_o=0, opnd1_o=opnd2_o=0, all pend=0, stall_o=0.
- Operand latency: 1 cycle from ID inputs to opnd*_o.
- stall_o is combinational in the same cycle. The upstream stage must hold its inputs while it is asserted.
- A writer with issue_lat_i=L blocks dependents for L cycles after its accept edge, counting only un-frozen cycles. A dependent is released early once its producer appears on a forwarding port with fwd_valid_i=1.
- Simultaneous flush_i and stall_i: flush wins.
- If rst is asserted mid-stall, the next cycle is in reset state with no pending entries.
- The counter never wraps: a decrement from 0 is suppressed.

## Test plan
- Forwarding priority: fwd0 and fwd1 both write r5, with data 0x11 and 0x22, both valid. ID reads r5 -> next cycle opnd1_o=0x11, stall_o=0.
- Load-use: a load to r3 is accepted with lat=1, and the next instruction reads r3 with fwd0 showing r3 valid=0 -> stall_o=1 for one cycle and valid_o=0 (bubble). Then fwd1 supplies r3=0xABCD valid -> opnd2_o=0xABCD.
- r0: ID reads r0 while fwd0 writes r0=0xFFFF valid -> opnd1_o=0, stall_o=0.
- Freeze: a writer to r7 with lat=2 is accepted, then stall_i=1 for 3 cycles, then released -> pend[r7] stays at 2 throughout and reaches 0 two cycles after release; the ID/EX fields hold during the freeze.
- Flush vs stall: flush_i=1 and stall_i=1 in the same cycle with a valid issue -> valid_o=0 and operands 0 next cycle, scoreboard unchanged.
- Reset mid-hazard: rst while stall_o=1 with pend[r4]=3 -> next cycle stall_o=0, pend[r4]=0, valid_o=0.
